// File: rtl/peripheral_ahb_initiator.sv
// ---------------------------------------------------------------------------
// peripheral_ahb_initiator
//
// AHB-Lite initiator that turns one command (address, size, beat count,
// direction) into a pipelined SINGLE/INCR burst. Write beats come from a
// valid/ready stream. Read beats leave as one-cycle strobes with no
// backpressure. Only one command is in flight at a time.
//
// Ports
//   hclk, hresetn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_write, cmd_addr, cmd_size
//                        (HSIZE encoding), cmd_len (beats minus one)
//   wdata_valid/ready    write beat stream; wdata is the beat payload
//   rdata_valid, rdata   read beat strobe and data
//   done, error          completion pulse; error is valid with done
//   haddr..hmastlock     AHB-Lite address phase
//   hwdata               AHB-Lite write data phase
//   hrdata, hready, hresp AHB-Lite slave response
//
// HADDR_SIZE must be at least 10, because the 1 KB boundary check looks at
// haddr[9:0]. The write source must hold wdata_valid and wdata until
// wdata_ready. This keeps a presented beat stable across wait states.
// ---------------------------------------------------------------------------
module peripheral_ahb_initiator #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int LEN_BITS   = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [LEN_BITS-1:0]   cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [HDATA_SIZE-1:0] wdata,
  output logic                  rdata_valid,
  output logic [HDATA_SIZE-1:0] rdata,
  output logic                  done,
  output logic                  error,
  output logic [HADDR_SIZE-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [1:0]            htrans,
  output logic                  hmastlock,
  output logic [HDATA_SIZE-1:0] hwdata,
  input  logic [HDATA_SIZE-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  state_t                state_q, state_d;
  logic [HADDR_SIZE-1:0] addr_q;     // address of the next beat to issue
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  incr_q;     // multi-beat command -> INCR
  logic [LEN_BITS-1:0]   beats_q;    // beats left after the one being issued
  logic                  started_q;  // at least one beat has been issued
  logic                  dphase_q;   // a data phase is in progress
  logic [HDATA_SIZE-1:0] hwdata_q;
  logic                  done_q, error_q;
  logic                  done_d, error_d;

  logic                  accept;
  logic                  issue;
  logic                  addr_done;
  logic                  err_first;
  logic [HADDR_SIZE-1:0] step;

  // cmd_ready is gated with hresetn so that it reads low while reset is held,
  // even though the state register already sits in IDLE.
  assign cmd_ready = hresetn && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = (state_q == ST_ADDR) && (!write_q || wdata_valid);
  assign addr_done = issue && hready;
  // The first cycle of a two-cycle ERROR response. Later beats are cancelled here.
  assign err_first = dphase_q && hresp && !hready;
  assign step      = HADDR_SIZE'(1) << size_q;

  assign wdata_ready = addr_done && write_q;
  assign rdata_valid = dphase_q && !write_q && hready && !hresp;
  assign rdata       = hrdata;
  assign done        = done_q;
  assign error       = error_q;
  assign haddr       = addr_q;
  assign hwrite      = write_q;
  assign hsize       = size_q;
  assign hburst      = incr_q ? HBURST_INCR : HBURST_SINGLE;
  assign hprot       = 4'b0011;
  assign hmastlock   = 1'b0;
  assign hwdata      = hwdata_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first. A path that is
  // left unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    htrans  = HTRANS_IDLE;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ADDR;
      ST_ADDR: begin
        if (issue)
          // The first beat is NONSEQ. A beat that lands on a 1 KB boundary
          // starts a new burst, so it is NONSEQ as well.
          htrans = (!started_q || addr_q[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        else
          htrans = started_q ? HTRANS_BUSY : HTRANS_IDLE;
        if (err_first)                        state_d = ST_ERR;
        else if (addr_done && beats_q == '0)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (err_first) state_d = ST_ERR;
        else if (hready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: if (hready) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        error_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever the statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      incr_q    <= 1'b0;
      beats_q   <= '0;
      started_q <= 1'b0;
      dphase_q  <= 1'b0;
      hwdata_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      error_q <= error_d;
      if (accept) begin
        addr_q    <= cmd_addr;
        write_q   <= cmd_write;
        size_q    <= cmd_size;
        incr_q    <= (cmd_len != '0);
        beats_q   <= cmd_len;
        started_q <= 1'b0;
      end
      if (err_first)   dphase_q <= 1'b0;
      else if (hready) dphase_q <= addr_done;
      if (addr_done) begin
        addr_q    <= addr_q + step;
        started_q <= 1'b1;
        if (beats_q != '0) beats_q <= beats_q - 1'b1;
        if (write_q) hwdata_q <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_ahb_initiator.sv
// ---------------------------------------------------------------------------
// tb_peripheral_ahb_initiator
//
// Directed bench for peripheral_ahb_initiator with default parameters. Each
// scenario accepts one command. It then runs a fixed number of cycles while
// playing the slave by hand. Every bus and stream output is compared against
// values worked out per cycle. Cycle k counts from the cycle after accept.
// ---------------------------------------------------------------------------
module tb_peripheral_ahb_initiator;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done, error;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hclk = ~hclk;

  peripheral_ahb_initiator dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .error(error),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [1:0] trans, input logic [31:0] addr);
    check({tag, "_htrans"}, htrans, trans);
    check({tag, "_haddr"}, haddr, addr);
  endtask

  // One clock cycle. Inputs change 2 time units after the rising edge.
  // Outputs can be checked 1 unit later, well away from either edge.
  task automatic cyc(input logic rdy, input logic rsp, input logic [31:0] rd,
                     input logic wv, input logic [31:0] wd);
    @(posedge hclk);
    #2;
    cmd_valid   = 1'b0;
    hready      = rdy;
    hresp       = rsp;
    hrdata      = rd;
    wdata_valid = wv;
    wdata       = wd;
    #1;
  endtask

  // Presents a command for one cycle and confirms that it is accepted.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [3:0] len);
    @(posedge hclk);
    #2;
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_size    = size;
    cmd_len     = len;
    hready      = 1'b1;
    hresp       = 1'b0;
    wdata_valid = 1'b0;
    #1;
    check("cmd_ready_at_accept", cmd_ready, 1'b1);
  endtask

  initial begin
    hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_len = '0; wdata_valid = 1'b0; wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;

    // Reset values
    #23;
    check("rst_htrans", htrans, T_IDLE);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", hwrite, 1'b0);
    check("rst_hburst", hburst, 3'd0);
    check("rst_hprot", hprot, 4'b0011);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge hclk); #2; hresetn = 1'b1; #1;
    check("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Single word write, zero wait
    issue_cmd(1'b1, 32'h10, 3'd2, 4'd0);
    cyc(1, 0, 0, 1, 32'hDEADBEEF);
    bus("t1", T_NSEQ, 32'h10);
    check("t1_hburst", hburst, 3'd0);
    check("t1_hwrite", hwrite, 1'b1);
    check("t1_hsize", hsize, 3'd2);
    check("t1_wready", wdata_ready, 1'b1);
    check("t1_hmastlock", hmastlock, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("t1_htrans_d", htrans, T_IDLE);
    check("t1_hwdata", hwdata, 32'hDEADBEEF);
    check("t1_done_early", done, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("t1_done", done, 1'b1);
    check("t1_error", error, 1'b0);

    // INCR4 read, zero wait; done at accept+6
    issue_cmd(1'b0, 32'h20, 3'd2, 4'd3);
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 32'hA0 + k - 2, 0, 0);
      if (k <= 4) bus("t2", (k == 1) ? T_NSEQ : T_SEQ, 32'h20 + 4 * (k - 1));
      if (k == 1) check("t2_hburst", hburst, 3'd1);
      if (k == 5) check("t2_htrans_end", htrans, T_IDLE);
      check("t2_rvalid", rdata_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("t2_rdata", rdata, 32'hA0 + k - 2);
      check("t2_done", done, (k == 6));
    end
    check("t2_error", error, 1'b0);

    // Write burst with the write stream stalling after the first beat
    issue_cmd(1'b1, 32'h0, 3'd2, 4'd3);
    cyc(1, 0, 0, 1, 32'h11110000);
    bus("t3_k1", T_NSEQ, 32'h0);
    check("t3_k1_wready", wdata_ready, 1'b1);
    cyc(1, 0, 0, 0, 0);
    bus("t3_k2", T_BUSY, 32'h4);
    check("t3_k2_wready", wdata_ready, 1'b0);
    check("t3_k2_hwdata", hwdata, 32'h11110000);
    cyc(1, 0, 0, 1, 32'h22221111);
    bus("t3_k3", T_SEQ, 32'h4);
    check("t3_k3_wready", wdata_ready, 1'b1);
    cyc(1, 0, 0, 1, 32'h33332222);
    bus("t3_k4", T_SEQ, 32'h8);
    check("t3_k4_hwdata", hwdata, 32'h22221111);
    cyc(1, 0, 0, 1, 32'h44443333);
    bus("t3_k5", T_SEQ, 32'hC);
    check("t3_k5_hwdata", hwdata, 32'h33332222);
    cyc(1, 0, 0, 0, 0);
    check("t3_k6_htrans", htrans, T_IDLE);
    check("t3_k6_hwdata", hwdata, 32'h44443333);
    check("t3_k6_done", done, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("t3_done", done, 1'b1);

    // Read burst with two wait states on the second data phase
    issue_cmd(1'b0, 32'h40, 3'd2, 4'd3);
    cyc(1, 0, 0, 0, 0);
    bus("t4_k1", T_NSEQ, 32'h40);
    cyc(1, 0, 32'hB0, 0, 0);
    bus("t4_k2", T_SEQ, 32'h44);
    check("t4_k2_rdata", rdata, 32'hB0);
    for (int k = 3; k <= 4; k++) begin
      cyc(0, 0, 32'hFF, 0, 0);
      bus("t4_wait", T_SEQ, 32'h48);
      check("t4_wait_hwdata", hwdata, 32'h44443333);
      check("t4_wait_rvalid", rdata_valid, 1'b0);
    end
    cyc(1, 0, 32'hB1, 0, 0);
    bus("t4_k5", T_SEQ, 32'h48);
    check("t4_k5_rvalid", rdata_valid, 1'b1);
    check("t4_k5_rdata", rdata, 32'hB1);
    cyc(1, 0, 32'hB2, 0, 0);
    bus("t4_k6", T_SEQ, 32'h4C);
    check("t4_k6_rdata", rdata, 32'hB2);
    cyc(1, 0, 32'hB3, 0, 0);
    check("t4_k7_htrans", htrans, T_IDLE);
    check("t4_k7_rvalid", rdata_valid, 1'b1);
    check("t4_k7_done", done, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("t4_done", done, 1'b1);

    // Read burst, ERROR on the second data phase
    issue_cmd(1'b0, 32'h80, 3'd2, 4'd3);
    cyc(1, 0, 0, 0, 0);
    bus("t5_k1", T_NSEQ, 32'h80);
    cyc(1, 0, 32'hC0, 0, 0);
    check("t5_k2_rvalid", rdata_valid, 1'b1);
    check("t5_k2_rdata", rdata, 32'hC0);
    cyc(0, 1, 32'hC1, 0, 0);
    check("t5_k3_rvalid", rdata_valid, 1'b0);
    cyc(1, 1, 32'hC1, 0, 0);
    check("t5_k4_htrans", htrans, T_IDLE);
    check("t5_k4_rvalid", rdata_valid, 1'b0);
    check("t5_k4_done", done, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("t5_done", done, 1'b1);
    check("t5_error", error, 1'b1);
    cyc(1, 0, 0, 0, 0);
    check("t5_done_once", done, 1'b0);
    check("t5_rvalid_after", rdata_valid, 1'b0);

    // 1 KB boundary crossing
    issue_cmd(1'b0, 32'h3F8, 3'd2, 4'd3);
    cyc(1, 0, 0, 0, 0); bus("t6_k1", T_NSEQ, 32'h3F8);
    cyc(1, 0, 0, 0, 0); bus("t6_k2", T_SEQ,  32'h3FC);
    cyc(1, 0, 0, 0, 0); bus("t6_k3", T_NSEQ, 32'h400);
    cyc(1, 0, 0, 0, 0); bus("t6_k4", T_SEQ,  32'h404);
    cyc(1, 0, 0, 0, 0); check("t6_k5_htrans", htrans, T_IDLE);
    cyc(1, 0, 0, 0, 0); check("t6_done", done, 1'b1);

    // Write data late for the first beat: the bus stays IDLE, not BUSY
    issue_cmd(1'b1, 32'h100, 3'd1, 4'd0);
    cyc(1, 0, 0, 0, 0);
    check("t7_k1_htrans", htrans, T_IDLE);
    check("t7_k1_wready", wdata_ready, 1'b0);
    cyc(1, 0, 0, 1, 32'h0000CAFE);
    bus("t7_k2", T_NSEQ, 32'h100);
    check("t7_k2_hsize", hsize, 3'd1);
    check("t7_k2_wready", wdata_ready, 1'b1);
    cyc(1, 0, 0, 0, 0);
    check("t7_k3_hwdata", hwdata, 32'h0000CAFE);
    cyc(1, 0, 0, 0, 0);
    check("t7_done", done, 1'b1);

    // Reset mid-burst abandons the command without a done pulse
    issue_cmd(1'b0, 32'h200, 3'd2, 4'd3);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 32'hD0, 0, 0);
    bus("t8_k2", T_SEQ, 32'h204);
    hresetn = 1'b0;
    #1;
    check("t8_rst_htrans", htrans, T_IDLE);
    check("t8_rst_haddr", haddr, 32'h0);
    check("t8_rst_cmd_ready", cmd_ready, 1'b0);
    check("t8_rst_rvalid", rdata_valid, 1'b0);
    @(posedge hclk); #2; hresetn = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0, 0, 0);
      check("t8_no_done", done, 1'b0);
      check("t8_idle_htrans", htrans, T_IDLE);
    end
    check("t8_cmd_ready", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
